// File: rtl/retry_pkg.sv
// Shared types and default parameters for the link-layer retry ack generator.
package retry_pkg;

  localparam int unsigned ACK_CNT_W        = 8;
  localparam int unsigned ACK_UNIT_DEF     = 8;
  localparam int unsigned LLCRD_THRESH_DEF = 16;
  localparam int unsigned ACK_TIMEOUT_DEF  = 64;

  typedef logic [ACK_CNT_W-1:0] ack_cnt_t;

  localparam ack_cnt_t ACK_CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    REQ  = 2'd2
  } ack_fsm_e;

endpackage

// File: rtl/ack_idle_timer.sv
// Clearable saturating idle counter; o_expired is high once the count has reached TIMEOUT.
module ack_idle_timer #(
  parameter int unsigned TIMEOUT = 64
) (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_clear,
  input  logic i_enable,
  output logic o_expired
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             expired_q, expired_d;

  // Count while enabled, saturate at TIMEOUT, clear has priority
  always_comb begin
    cnt_d = cnt_q;
    if (i_clear) begin
      cnt_d = '0;
    end else if (i_enable && (cnt_q != CNT_W'(TIMEOUT))) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    expired_d = (cnt_d == CNT_W'(TIMEOUT));
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt_q     <= '0;
      expired_q <= 1'b0;
    end else begin
      cnt_q     <= cnt_d;
      expired_q <= expired_d;
    end
  end

  assign o_expired = expired_q;

endmodule

// File: rtl/retry_ack_gen.sv
// Receive-side ack generator: returns pending acks via Full_Ack bits or LLCRD ack flits.
// Optional idle timer built when RETRY_ACK_TIMEOUT_EN is defined.
module retry_ack_gen
  import retry_pkg::*;
#(
  parameter int unsigned ACK_UNIT     = ACK_UNIT_DEF,
  parameter int unsigned LLCRD_THRESH = LLCRD_THRESH_DEF,
  parameter int unsigned ACK_TIMEOUT  = ACK_TIMEOUT_DEF
) (
  input  logic           i_clk,
  input  logic           i_rst,
  input  logic           i_rx_flit_acked,
  input  logic           i_tx_prot_flit_sent,
  input  logic           i_llcrd_grant,
  input  logic           i_force_ack,
  output logic           o_full_ack_avail,
  output logic           o_llcrd_req,
  output logic [7:0]     o_llcrd_ack_val,
  output logic [7:0]     o_num_ack,
  output logic           o_ack_overflow
);

  ack_fsm_e state_q, state_d;
  ack_cnt_t num_ack_q, num_ack_d;
  ack_cnt_t ack_val_q, ack_val_d;
  logic     full_ack_q, full_ack_d;
  logic     llcrd_req_q, llcrd_req_d;
  logic     overflow_q, overflow_d;

  logic     grant_c;
  logic     full_dec_c;
  logic     sat_c;
  ack_cnt_t base_c;
  logic     timer_exp;

`ifdef RETRY_ACK_TIMEOUT_EN
  // Timer runs only in WAIT; leaving WAIT or sending a protocol flit restarts it
  ack_idle_timer #(
    .TIMEOUT (ACK_TIMEOUT)
  ) u_idle_timer (
    .i_clk     (i_clk),
    .i_rst     (i_rst),
    .i_clear   ((state_q != WAIT) || i_tx_prot_flit_sent),
    .i_enable  (state_q == WAIT),
    .o_expired (timer_exp)
  );
`else
  // No timer: the timeout parameter folds away to a constant-false expiry
  assign timer_exp = 1'b0 && (ACK_TIMEOUT > 0);
`endif

  // Pending-ack counter: a grant returns everything, else a Full_Ack returns ACK_UNIT
  always_comb begin
    grant_c    = i_llcrd_grant && llcrd_req_q;
    full_dec_c = i_tx_prot_flit_sent && full_ack_q;
    base_c     = num_ack_q;
    if (grant_c) begin
      base_c = '0;
    end else if (full_dec_c) begin
      base_c = num_ack_q - ack_cnt_t'(ACK_UNIT);
    end
    sat_c      = i_rx_flit_acked && (base_c == ACK_CNT_MAX);
    num_ack_d  = (i_rx_flit_acked && !sat_c) ? base_c + ack_cnt_t'(1) : base_c;
    overflow_d = overflow_q | sat_c;
  end

  // Next-state and registered-output decode
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (num_ack_d != '0) state_d = WAIT;
      end
      WAIT: begin
        if (num_ack_d == '0) begin
          state_d = IDLE;
        end else if ((num_ack_q >= ack_cnt_t'(LLCRD_THRESH)) || i_force_ack || timer_exp) begin
          state_d = REQ;
        end
      end
      REQ: begin
        if (grant_c) begin
          state_d = i_rx_flit_acked ? WAIT : IDLE;
        end else if (num_ack_d == '0) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    full_ack_d  = (num_ack_d >= ack_cnt_t'(ACK_UNIT));
    llcrd_req_d = (state_d == REQ);
    ack_val_d   = (state_d == REQ) ? num_ack_d : '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q     <= IDLE;
      num_ack_q   <= '0;
      ack_val_q   <= '0;
      full_ack_q  <= 1'b0;
      llcrd_req_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      num_ack_q   <= num_ack_d;
      ack_val_q   <= ack_val_d;
      full_ack_q  <= full_ack_d;
      llcrd_req_q <= llcrd_req_d;
      overflow_q  <= overflow_d;
    end
  end

  assign o_full_ack_avail = full_ack_q;
  assign o_llcrd_req      = llcrd_req_q;
  assign o_llcrd_ack_val  = ack_val_q;
  assign o_num_ack        = num_ack_q;
  assign o_ack_overflow   = overflow_q;

endmodule

// File: tb/tb_retry_ack_gen.sv
// Directed table-driven bench for retry_ack_gen, plus timer and saturation sequences.
module tb_retry_ack_gen;

  logic       i_clk = 1'b0;
  logic       i_rst;
  logic       i_rx_flit_acked;
  logic       i_tx_prot_flit_sent;
  logic       i_llcrd_grant;
  logic       i_force_ack;
  logic       o_full_ack_avail;
  logic       o_llcrd_req;
  logic [7:0] o_llcrd_ack_val;
  logic [7:0] o_num_ack;
  logic       o_ack_overflow;

  int checks = 0;
  int errors = 0;

  retry_ack_gen dut (
    .i_clk               (i_clk),
    .i_rst               (i_rst),
    .i_rx_flit_acked     (i_rx_flit_acked),
    .i_tx_prot_flit_sent (i_tx_prot_flit_sent),
    .i_llcrd_grant       (i_llcrd_grant),
    .i_force_ack         (i_force_ack),
    .o_full_ack_avail    (o_full_ack_avail),
    .o_llcrd_req         (o_llcrd_req),
    .o_llcrd_ack_val     (o_llcrd_ack_val),
    .o_num_ack           (o_num_ack),
    .o_ack_overflow      (o_ack_overflow)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic       rx;
    logic       tx;
    logic       gr;
    logic       fo;
    logic [7:0] num;
    logic       fa;
    logic       req;
    logic [7:0] val;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(logic rx, logic tx, logic gr, logic fo,
                              logic [7:0] num, logic fa, logic req, logic [7:0] val);
    vec_t v;
    v.rx = rx; v.tx = tx; v.gr = gr; v.fo = fo;
    v.num = num; v.fa = fa; v.req = req; v.val = val;
    vecs.push_back(v);
  endfunction

  task automatic chk(input string name, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic idle_inputs();
    i_rx_flit_acked     = 1'b0;
    i_tx_prot_flit_sent = 1'b0;
    i_llcrd_grant       = 1'b0;
    i_force_ack         = 1'b0;
  endtask

  task automatic do_reset();
    idle_inputs();
    i_rst = 1'b1;
    step();
    step();
    i_rst = 1'b0;
  endtask

  initial begin
    bit seen;
    int waited;

    // Eight acks raise Full_Ack, one protocol flit returns them
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 0, 8'(i), (i >= 8), 0, 0);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // Sixteen acks with no traffic force an LLCRD request of 16, grant empties it
    for (int i = 1; i <= 16; i++) add(1, 0, 0, 0, 8'(i), (i >= 8), 0, 0);
    add(0, 0, 0, 0, 16, 1, 1, 16);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Count 9 forced into REQ, grant plus new ack leaves 1 in WAIT
    for (int i = 1; i <= 9; i++) add(1, 0, 0, 0, 8'(i), (i >= 8), 0, 0);
    add(0, 0, 0, 1, 9, 1, 1, 9);
    add(1, 0, 1, 0, 1, 0, 0, 0);
    add(0, 0, 0, 1, 1, 0, 1, 1);
    add(0, 0, 1, 0, 0, 0, 0, 0);
    // Force in IDLE is ignored
    add(0, 0, 0, 1, 0, 0, 0, 0);
    // Count 8 forced, then a Full_Ack drains it and the request drops
    for (int i = 1; i <= 8; i++) add(1, 0, 0, 0, 8'(i), (i >= 8), 0, 0);
    add(0, 0, 0, 1, 8, 1, 1, 8);
    add(0, 1, 0, 0, 0, 0, 0, 0);
    // Grants without a request are ignored
    add(0, 0, 1, 0, 0, 0, 0, 0);
    add(1, 0, 0, 0, 1, 0, 0, 0);
    add(0, 0, 1, 0, 1, 0, 0, 0);
    // Protocol flit with Full_Ack low does not decrement
    add(0, 1, 0, 0, 1, 0, 0, 0);

    do_reset();
    chk("rst_num", 0, o_num_ack, 0);
    chk("rst_fa", 0, o_full_ack_avail, 0);
    chk("rst_req", 0, o_llcrd_req, 0);
    chk("rst_val", 0, o_llcrd_ack_val, 0);
    chk("rst_ovf", 0, o_ack_overflow, 0);

    for (int i = 0; i < vecs.size(); i++) begin
      i_rx_flit_acked     = vecs[i].rx;
      i_tx_prot_flit_sent = vecs[i].tx;
      i_llcrd_grant       = vecs[i].gr;
      i_force_ack         = vecs[i].fo;
      step();
      chk("num", i, o_num_ack, vecs[i].num);
      chk("fa", i, o_full_ack_avail, vecs[i].fa);
      chk("req", i, o_llcrd_req, vecs[i].req);
      chk("val", i, o_llcrd_ack_val, vecs[i].val);
    end
    idle_inputs();

    // Idle timeout with three pending acks
    do_reset();
    for (int i = 0; i < 3; i++) begin
      i_rx_flit_acked = 1'b1;
      step();
    end
    i_rx_flit_acked = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      step();
      if (o_llcrd_req) seen = 1'b1;
    end
    chk("tmo_early_req", 0, seen, 0);
    waited = 0;
    while (!o_llcrd_req && waited < 60) begin
      step();
      waited++;
    end
`ifdef RETRY_ACK_TIMEOUT_EN
    chk("tmo_req", 0, o_llcrd_req, 1);
    chk("tmo_val", 0, o_llcrd_ack_val, 3);
`else
    chk("tmo_req", 0, o_llcrd_req, 0);
    chk("tmo_val", 0, o_llcrd_ack_val, 0);
`endif
    chk("tmo_num", 0, o_num_ack, 3);

    // Saturation at 255, sticky overflow, reset mid-request
    do_reset();
    i_rx_flit_acked = 1'b1;
    for (int i = 0; i < 255; i++) step();
    i_rx_flit_acked = 1'b0;
    chk("sat_num", 0, o_num_ack, 255);
    chk("sat_ovf_pre", 0, o_ack_overflow, 0);
    chk("sat_req", 0, o_llcrd_req, 1);
    chk("sat_val", 0, o_llcrd_ack_val, 255);
    i_rx_flit_acked = 1'b1;
    step();
    i_rx_flit_acked = 1'b0;
    chk("sat_num", 1, o_num_ack, 255);
    chk("sat_ovf", 1, o_ack_overflow, 1);
    for (int i = 0; i < 5; i++) step();
    chk("sat_ovf_hold", 0, o_ack_overflow, 1);
    i_rst = 1'b1;
    step();
    i_rst = 1'b0;
    chk("rst2_req", 0, o_llcrd_req, 0);
    chk("rst2_num", 0, o_num_ack, 0);
    chk("rst2_ovf", 0, o_ack_overflow, 0);
    chk("rst2_val", 0, o_llcrd_ack_val, 0);
    chk("rst2_fa", 0, o_full_ack_avail, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
